// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port among NUM_PORTS requesters.
// One transaction in flight at a time, with an optional response timeout.
module mem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 0,
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]   req_byte_enable,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_resp,
  output logic [NUM_PORTS-1:0]            req_err,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [BE_WIDTH-1:0]             mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic                            mem_resp,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_grant;
  logic                r_is_write;
  logic                r_timed_out;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_WIDTH-1:0]   r_be;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [CNT_W-1:0]    r_cnt;

  logic [NUM_PORTS-1:0] w_pending;
  logic                 w_found;
  logic [PTR_W-1:0]     w_grant;
  logic [PTR_W-1:0]     w_idx;
  logic [PTR_W-1:0]     w_ptr_next;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_timeout;
  logic                 w_grant_now;

  assign w_pending   = req_read | req_write;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_timeout   = (TIMEOUT != 0) && (w_cnt_inc == TIMEOUT_C);
  assign w_grant_now = (r_state == StIdle) && w_found;
  assign w_ptr_next  = (w_grant == PTR_W'(NUM_PORTS - 1)) ? '0 : w_grant + PTR_W'(1);

  // First pending port at or after the round-robin pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_idx = PTR_W'((32'(r_rr_ptr) + i) % NUM_PORTS);
      if (!w_found && w_pending[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_found) w_state_next = StBusy;
      StBusy:  if (mem_resp || w_timeout) w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    mem_read  = (r_state == StBusy) && !r_is_write;
    mem_write = (r_state == StBusy) && r_is_write;
    req_resp  = '0;
    req_err   = '0;
    if (r_state == StResp) begin
      req_resp[r_grant] = 1'b1;
      req_err[r_grant]  = r_timed_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_is_write  <= 1'b0;
      r_timed_out <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_grant_now) begin
        r_grant     <= w_grant;
        r_rr_ptr    <= w_ptr_next;
        // A simultaneous read+write request is served as a write.
        r_is_write  <= req_write[w_grant];
        r_addr      <= req_address[32'(w_grant) * ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata     <= req_wdata[32'(w_grant) * DATA_WIDTH +: DATA_WIDTH];
        r_be        <= req_byte_enable[32'(w_grant) * BE_WIDTH +: BE_WIDTH];
        r_cnt       <= '0;
        r_timed_out <= 1'b0;
      end
      if (r_state == StBusy) begin
        r_cnt       <= w_cnt_inc;
        r_timed_out <= w_timeout && !mem_resp;
        if (mem_resp && !r_is_write) begin
          r_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_address     = r_addr;
  assign mem_wdata       = r_wdata;
  assign mem_byte_enable = r_be;
  assign req_rdata       = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a 2-port arbiter with TIMEOUT=4 for the transaction scenarios and a
// 4-port arbiter with continuous requests for round-robin fairness.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  logic b_rst_n;

  logic [1:0]  req_read, req_write, req_resp, req_err;
  logic [7:0]  req_be;
  logic [63:0] req_address, req_wdata;
  logic [31:0] req_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [3:0]  mem_be;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  logic [3:0]   b_req_read, b_req_write, b_req_resp, b_req_err;
  logic [15:0]  b_req_be;
  logic [127:0] b_req_address, b_req_wdata;
  logic [31:0]  b_req_rdata;
  logic         b_mem_read, b_mem_write, b_mem_resp;
  logic [3:0]   b_mem_be;
  logic [31:0]  b_mem_address, b_mem_wdata, b_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  int          s_first, s_busy;
  logic [1:0]  s_resp, s_err;
  logic        s_rd, s_wr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;

  mem_arbiter #(
    .NUM_PORTS (2),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (4)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_byte_enable(req_be),
    .req_address    (req_address),
    .req_wdata      (req_wdata),
    .req_resp       (req_resp),
    .req_err        (req_err),
    .req_rdata      (req_rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_enable(mem_be),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_resp       (mem_resp),
    .mem_rdata      (mem_rdata)
  );

  mem_arbiter #(
    .NUM_PORTS (4),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (0)
  ) u_dut4 (
    .clk            (clk),
    .rst_n          (b_rst_n),
    .req_read       (b_req_read),
    .req_write      (b_req_write),
    .req_byte_enable(b_req_be),
    .req_address    (b_req_address),
    .req_wdata      (b_req_wdata),
    .req_resp       (b_req_resp),
    .req_err        (b_req_err),
    .req_rdata      (b_req_rdata),
    .mem_read       (b_mem_read),
    .mem_write      (b_mem_write),
    .mem_byte_enable(b_mem_be),
    .mem_address    (b_mem_address),
    .mem_wdata      (b_mem_wdata),
    .mem_resp       (b_mem_resp),
    .mem_rdata      (b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model for the 2-port DUT: answers after lat busy cycles (0 = never).
  task automatic serve(input int lat, input logic [31:0] rd);
    s_first = -1;
    s_busy  = 0;
    s_resp  = '0;
    s_err   = '0;
    s_rd    = 1'b0;
    s_wr    = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_resp != 2'b00) begin
        s_resp = req_resp;
        s_err  = req_err;
        break;
      end
      if (mem_read || mem_write) begin
        s_busy++;
        if (s_busy == 1) begin
          s_first = c;
          s_addr  = mem_address;
          s_wdata = mem_wdata;
          s_be    = mem_be;
        end
        s_rd = s_rd | mem_read;
        s_wr = s_wr | mem_write;
      end
      mem_resp  = (lat > 0) && (s_busy == lat);
      mem_rdata = rd;
    end
    mem_resp = 1'b0;
  endtask

  task automatic idle_gap(input string tag);
    @(negedge clk);
    check_eq(tag, 32'(req_resp), 32'h0);
  endtask

  initial begin
    int n_grant;
    rst_n = 1'b0;  b_rst_n = 1'b0;
    req_read = '0; req_write = '0; req_be = '0; req_address = '0; req_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    b_req_read = 4'hF; b_req_write = '0; b_req_be = '1; b_req_wdata = '0;
    b_req_address = {32'h300, 32'h200, 32'h100, 32'h0};
    b_mem_resp = 1'b1; b_mem_rdata = 32'h5A5A_0000;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mem_read", 32'(mem_read), 32'h0);
    check_eq("rst_mem_write", 32'(mem_write), 32'h0);
    check_eq("rst_req_resp", 32'(req_resp), 32'h0);
    check_eq("rst_rdata", req_rdata, 32'h0);
    check_eq("rst_addr", mem_address, 32'h0);
    rst_n = 1'b1;

    // Single read, three busy cycles
    req_address[31:0] = 32'h0000_1000;
    req_read = 2'b01;
    serve(3, 32'hDEAD_BEEF);
    check_eq("rd_first", 32'(s_first), 32'h0);
    check_eq("rd_busy", 32'(s_busy), 32'h3);
    check_eq("rd_resp", 32'(s_resp), 32'h1);
    check_eq("rd_err", 32'(s_err), 32'h0);
    check_eq("rd_op_write", 32'(s_wr), 32'h0);
    check_eq("rd_addr", s_addr, 32'h0000_1000);
    check_eq("rd_rdata", req_rdata, 32'hDEAD_BEEF);
    req_read = '0;
    idle_gap("rd_pulse");

    // Back to reset so contention starts from port 0
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst2_rdata", req_rdata, 32'h0);
    rst_n = 1'b1;

    // Contention: 0 first, then 1; port 0 re-requests and follows port 1
    req_address = {32'h200, 32'h100};
    req_read = 2'b11;
    serve(1, 32'h1111_1111);
    check_eq("ct_a_resp", 32'(s_resp), 32'h1);
    check_eq("ct_a_addr", s_addr, 32'h100);
    req_read[0] = 1'b0;
    idle_gap("ct_a_pulse");
    req_address[31:0] = 32'h300;
    req_read[0] = 1'b1;
    serve(2, 32'h2222_2222);
    check_eq("ct_b_resp", 32'(s_resp), 32'h2);
    check_eq("ct_b_addr", s_addr, 32'h200);
    check_eq("ct_b_rdata", req_rdata, 32'h2222_2222);
    req_read[1] = 1'b0;
    idle_gap("ct_b_pulse");
    serve(1, 32'h3333_3333);
    check_eq("ct_c_resp", 32'(s_resp), 32'h1);
    check_eq("ct_c_addr", s_addr, 32'h300);
    req_read = '0;

    // Write passthrough on port 1
    idle_gap("wr_gap");
    req_address[63:32] = 32'h40;
    req_wdata[63:32] = 32'h1234_5678;
    req_be[7:4] = 4'b0011;
    req_write = 2'b10;
    serve(2, 32'hFFFF_FFFF);
    check_eq("wr_resp", 32'(s_resp), 32'h2);
    check_eq("wr_op_write", 32'(s_wr), 32'h1);
    check_eq("wr_op_read", 32'(s_rd), 32'h0);
    check_eq("wr_addr", s_addr, 32'h40);
    check_eq("wr_wdata", s_wdata, 32'h1234_5678);
    check_eq("wr_be", 32'(s_be), 32'h3);
    check_eq("wr_rdata_kept", req_rdata, 32'h3333_3333);
    req_write = '0;

    // Read and write together is a write
    idle_gap("rw_gap");
    req_address[31:0] = 32'h80;
    req_wdata[31:0] = 32'hA5A5_A5A5;
    req_be[3:0] = 4'hF;
    req_read = 2'b01;
    req_write = 2'b01;
    serve(1, 32'h5555_5555);
    check_eq("rw_op_write", 32'(s_wr), 32'h1);
    check_eq("rw_op_read", 32'(s_rd), 32'h0);
    check_eq("rw_wdata", s_wdata, 32'hA5A5_A5A5);
    check_eq("rw_rdata_kept", req_rdata, 32'h3333_3333);
    req_read = '0;
    req_write = '0;

    // Timeout: no mem_resp at all
    idle_gap("to_gap");
    req_address[31:0] = 32'h500;
    req_read = 2'b01;
    serve(0, 32'h6666_6666);
    check_eq("to_busy", 32'(s_busy), 32'h4);
    check_eq("to_resp", 32'(s_resp), 32'h1);
    check_eq("to_err", 32'(s_err), 32'h1);
    check_eq("to_rdata_kept", req_rdata, 32'h3333_3333);
    req_read = '0;
    idle_gap("to_pulse");
    check_eq("to_err_pulse", 32'(req_err), 32'h0);

    // mem_resp on the very cycle the counter would expire completes normally
    req_address[63:32] = 32'h600;
    req_read = 2'b10;
    serve(4, 32'hCAFE_F00D);
    check_eq("edge_busy", 32'(s_busy), 32'h4);
    check_eq("edge_resp", 32'(s_resp), 32'h2);
    check_eq("edge_err", 32'(s_err), 32'h0);
    check_eq("edge_rdata", req_rdata, 32'hCAFE_F00D);
    req_read = '0;

    // Stray mem_resp while idle
    idle_gap("stray_gap");
    mem_resp = 1'b1;
    mem_rdata = 32'h7777_7777;
    repeat (3) @(negedge clk);
    check_eq("stray_resp", 32'(req_resp), 32'h0);
    check_eq("stray_read", 32'(mem_read), 32'h0);
    check_eq("stray_rdata", req_rdata, 32'hCAFE_F00D);
    mem_resp = 1'b0;

    // Reset mid-busy, then both ports request and port 0 wins again
    req_address = {32'h910, 32'h900};
    req_read = 2'b01;
    @(negedge clk);
    check_eq("mid_busy", 32'(mem_read), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_async_drop", 32'(mem_read), 32'h0);
    req_read = 2'b11;
    @(negedge clk);
    check_eq("mid_no_resp", 32'(req_resp), 32'h0);
    check_eq("mid_rdata_rst", req_rdata, 32'h0);
    rst_n = 1'b1;
    serve(2, 32'h0BAD_F00D);
    check_eq("mid_re_first", 32'(s_first), 32'h0);
    check_eq("mid_re_resp", 32'(s_resp), 32'h1);
    check_eq("mid_re_addr", s_addr, 32'h900);
    check_eq("mid_re_rdata", req_rdata, 32'h0BAD_F00D);
    req_read[0] = 1'b0;
    serve(1, 32'h1212_1212);
    check_eq("mid_p1_resp", 32'(s_resp), 32'h2);
    req_read = '0;

    // Four ports always requesting: grants rotate 0,1,2,3,0,...
    @(negedge clk);
    b_rst_n = 1'b1;
    n_grant = 0;
    for (int c = 0; c < 60 && n_grant < 8; c++) begin
      @(negedge clk);
      if (b_req_resp != 4'h0) begin
        check_eq($sformatf("rr4_grant%0d", n_grant), 32'(b_req_resp), 32'(1 << (n_grant % 4)));
        n_grant++;
      end
    end
    check_eq("rr4_count", 32'(n_grant), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001: Parameter NUM_PORTS, default 2, number of requester ports (1..8).
- REQ-002: Parameter ADDR_WIDTH, default 32, address width.
- REQ-003: Parameter DATA_WIDTH, default 32, data width (multiple of 8); BE_WIDTH = DATA_WIDTH/8.
- REQ-004: Parameter TIMEOUT, default 0, maximum cycles to wait for mem_resp; 0 disables the timeout.
- REQ-005: clk  in  1  single clock; all state updates on the rising edge.
- REQ-006: rst_n  in  1  reset, asynchronous and active-low.
- REQ-007: req_read  in  NUM_PORTS  per-port read request.
- REQ-008: req_write  in  NUM_PORTS  per-port write request.
- REQ-009: req_byte_enable  in  NUM_PORTS*BE_WIDTH  per-port byte enables; port i occupies slice i.
- REQ-010: req_address  in  NUM_PORTS*ADDR_WIDTH  per-port address.
- REQ-011: req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- REQ-012: req_resp  out  NUM_PORTS  per-port one-cycle completion pulse.
- REQ-013: req_err  out  NUM_PORTS  per-port one-cycle timeout pulse, coincident with req_resp.
- REQ-014: req_rdata  out  DATA_WIDTH  shared read-data return.
- REQ-015: mem_read, mem_write  out  1 each  downstream request strobes.
- REQ-016: mem_byte_enable  out  BE_WIDTH; mem_address  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH.
- REQ-017: mem_resp  in  1; mem_rdata  in  DATA_WIDTH  downstream completion and read data.

Function
- REQ-018: Requester protocol: port holds read/write and all fields stable until its req_resp pulse, then deasserts its request on the following edge.
- REQ-019: FSM states IDLE, BUSY, RESP; IDLE->BUSY on any pending request; BUSY->RESP on mem_resp or timeout; RESP->IDLE unconditionally.
- REQ-020: In IDLE, grant goes to the first pending port at or after rr_ptr, searching upward modulo NUM_PORTS; rr_ptr becomes grant+1 (mod NUM_PORTS) on grant.
- REQ-021: On grant, operation, address, byte enables and wdata of the granted port are latched; mem_* are driven only from these registers.
- REQ-022: A port asserting both req_read and req_write is served as a write only.
- REQ-023: mem_read/mem_write are high in every BUSY cycle and low in IDLE and RESP; mem_address/mem_wdata/mem_byte_enable hold latched values outside BUSY.
- REQ-024: Latency: request first visible in IDLE at cycle t -> mem strobe high at cycle t+1; mem_resp in cycle t+k -> req_resp[grant] high at cycle t+k+1 only.
- REQ-025: On mem_resp during a read, mem_rdata is captured into req_rdata; req_rdata holds until the next captured read; writes do not alter it.
- REQ-026: mem_resp sampled outside BUSY is ignored.
- REQ-027: With TIMEOUT>0, a counter cleared on grant increments each BUSY cycle; reaching TIMEOUT without mem_resp enters RESP with req_resp and req_err both pulsed and req_rdata unchanged.
- REQ-028: mem_resp in the same cycle the counter reaches TIMEOUT completes normally, with no req_err.
- REQ-029: Requests arriving during BUSY or RESP wait; no request is lost or duplicated.
- REQ-030: At most one req_resp bit is high in any cycle.

Reset
- REQ-031: rst_n low immediately forces IDLE, rr_ptr=0, counter=0, req_rdata=0, latched fields=0, and all outputs low.
- REQ-032: Reset mid-transaction abandons it with no req_resp; after release, arbitration restarts from port 0.

Verification
- REQ-033: Single read: port 0 reads 0x0000_1000, mem_resp after 3 cycles with 0xDEAD_BEEF -> mem_read high for 3 cycles, req_resp[0] pulses 1 cycle, req_rdata=0xDEAD_BEEF.
- REQ-034: Contention: ports 0 and 1 request together from reset -> port 0 served first, then port 1; the next simultaneous pair serves port 1 then port 0.
- REQ-035: Write passthrough: port 1 writes 0x1234_5678 to 0x40 with BE=4'b0011 -> mem_write with identical fields; req_rdata unchanged.
- REQ-036: Timeout: TIMEOUT=4, mem_resp never asserted -> mem_read high 4 cycles, then req_resp and req_err pulse together.
- REQ-037: Reset mid-BUSY -> mem_read drops asynchronously, no req_resp; a reissued request completes normally.
- REQ-038: NUM_PORTS=4 with all ports continuously requesting -> grants cycle 0,1,2,3,0 and no port waits more than 3 transactions.
